// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 hex display driver: command bytes,
// sequencer and bus-phase encodings, and the nibble-to-ASCII helper.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CHAR_ZERO    = 8'h30;
  localparam logic [7:0] CHAR_X       = 8'h78;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SET_ADDR,
    ST_WR_CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } bus_phase_t;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD bus write: SETUP (1 cycle), EN pulse, then post-write wait.
// Start pulse in, done pulse out one cycle after the wait expires.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYCLES    = 16,
  parameter int CMD_WAIT_CYCLES   = 2600,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_en,
  output logic       o_rs,
  output logic [7:0] o_data,
  output logic       o_done
);

  localparam int MAX_A = (CLEAR_WAIT_CYCLES > EN_HIGH_CYCLES) ? CLEAR_WAIT_CYCLES : EN_HIGH_CYCLES;
  localparam int MAXV  = (MAX_A > CMD_WAIT_CYCLES) ? MAX_A : CMD_WAIT_CYCLES;
  localparam int CW    = $clog2(MAXV + 1);

  localparam logic [CW-1:0] EN_LOAD    = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_WAIT_CYCLES - 1);

  bus_phase_t    r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_done;
  logic          w_is_clear;

  assign w_is_clear = !r_rs && (r_data == CMD_CLEAR);

  // Down-counters load N-1 so each phase lasts exactly N cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          if (i_start) begin
            r_rs    <= i_rs;
            r_data  <= i_data;
            r_phase <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          r_en    <= 1'b1;
          r_cnt   <= EN_LOAD;
          r_phase <= PH_PULSE;
        end
        PH_PULSE: begin
          if (r_cnt == '0) begin
            r_en    <= 1'b0;
            r_cnt   <= w_is_clear ? CLEAR_LOAD : CMD_LOAD;
            r_phase <= PH_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_done  <= 1'b1;
            r_phase <= PH_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign o_en   = r_en;
  assign o_rs   = r_rs;
  assign o_data = r_data;
  assign o_done = r_done;

endmodule

// File: rtl/lcd_hex_driver.sv
// Drives a 16x2 HD44780 LCD: init sequence, then line 1 refreshed with Msg as 8 hex digits.
// Define LCD_PREFIX_EN to emit a "0x" prefix ahead of the digits.
module lcd_hex_driver
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYCLES    = 16,
  parameter int CMD_WAIT_CYCLES   = 2600,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] Msg,
  output logic        oREADY,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_RS
);

`ifdef LCD_PREFIX_EN
  localparam logic [3:0] LAST_CHAR = 4'd9;
`else
  localparam logic [3:0] LAST_CHAR = 4'd7;
`endif

  lcd_state_t  r_state;
  logic [3:0]  r_idx;
  logic [31:0] r_snap;
  logic        r_ready;
  logic        r_wait;
  logic        r_start;
  logic        r_cmd_rs;
  logic [7:0]  r_cmd_data;

  logic        w_done;
  logic [2:0]  w_dig_idx;
  logic [4:0]  w_shift;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;

`ifdef LCD_PREFIX_EN
  assign w_dig_idx = 3'(r_idx - 4'd2);
`else
  assign w_dig_idx = r_idx[2:0];
`endif

  // Digit 0 is the most significant nibble of the frame snapshot.
  assign w_shift = {3'd7 - w_dig_idx, 2'b00};
  assign w_nib   = r_snap[w_shift +: 4];

  always_comb begin
    w_char = nib2ascii(w_nib);
`ifdef LCD_PREFIX_EN
    if (r_idx == 4'd0)      w_char = CHAR_ZERO;
    else if (r_idx == 4'd1) w_char = CHAR_X;
`endif
  end

  // r_wait: a transaction is in flight; the next byte is issued once done returns.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= ST_INIT;
      r_idx      <= 4'd0;
      r_snap     <= 32'h0;
      r_ready    <= 1'b0;
      r_wait     <= 1'b0;
      r_start    <= 1'b0;
      r_cmd_rs   <= 1'b0;
      r_cmd_data <= 8'h00;
    end else begin
      r_start <= 1'b0;
      if (!r_wait) begin
        r_start <= 1'b1;
        r_wait  <= 1'b1;
        case (r_state)
          ST_INIT: begin
            r_cmd_rs   <= 1'b0;
            r_cmd_data <= init_cmd(r_idx[1:0]);
          end
          ST_SET_ADDR: begin
            r_cmd_rs   <= 1'b0;
            r_cmd_data <= CMD_LINE1;
          end
          default: begin
            r_cmd_rs   <= 1'b1;
            r_cmd_data <= w_char;
          end
        endcase
      end else if (w_done) begin
        r_wait <= 1'b0;
        case (r_state)
          ST_INIT: begin
            if (r_idx == 4'd3) begin
              r_state <= ST_SET_ADDR;
              r_idx   <= 4'd0;
              r_snap  <= Msg;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
          ST_SET_ADDR: begin
            r_state <= ST_WR_CHAR;
            r_idx   <= 4'd0;
          end
          default: begin
            if (r_idx == LAST_CHAR) begin
              r_state <= ST_SET_ADDR;
              r_idx   <= 4'd0;
              r_snap  <= Msg;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        endcase
      end
    end
  end

  lcd_bus_cycle #(
    .EN_HIGH_CYCLES   (EN_HIGH_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_bus (
    .i_clk  (iCLK),
    .i_rst_n(iRST_N),
    .i_start(r_start),
    .i_rs   (r_cmd_rs),
    .i_data (r_cmd_data),
    .o_en   (LCD_EN),
    .o_rs   (LCD_RS),
    .o_data (LCD_DATA),
    .o_done (w_done)
  );

  assign oREADY = r_ready;
  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Self-checking bench for lcd_hex_driver: a bus monitor captures every EN pulse,
// expected bytes are queued as stimulus is applied and compared in order.
module tb_lcd_hex_driver;

  localparam int EN_HIGH    = 2;
  localparam int CMD_WAIT   = 4;
  localparam int CLEAR_WAIT = 8;
  // EN-low cycles beyond the wait: done cycle, sequencer reload, start, setup.
  localparam int GAP_OVH    = 4;
  localparam int TMO        = 2000;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [31:0] Msg = 32'h0;
  logic        oREADY;
  logic [7:0]  LCD_DATA;
  logic        LCD_RW;
  logic        LCD_EN;
  logic        LCD_RS;

  always #5 iCLK = ~iCLK;

  lcd_hex_driver #(
    .EN_HIGH_CYCLES   (EN_HIGH),
    .CMD_WAIT_CYCLES  (CMD_WAIT),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT)
  ) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .Msg     (Msg),
    .oREADY  (oREADY),
    .LCD_DATA(LCD_DATA),
    .LCD_RW  (LCD_RW),
    .LCD_EN  (LCD_EN),
    .LCD_RS  (LCD_RS)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         hi;
    int         gap;
    int         exp_gap;
    bit         gap_valid;
    bit         stable;
    bit         ready;
  } pulse_t;

  typedef struct {
    logic [31:0] msg;
    logic [63:0] ascii;
  } vec_t;

  pulse_t      obs_q[$];
  logic [8:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rw_bad = 0;

  // Bus monitor
  pulse_t     cur;
  bit         in_pulse = 0;
  bit         first = 1;
  bit         last_clear = 0;
  int         hi_cnt = 0;
  int         low_cnt = 0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge iCLK) begin
    if (LCD_RW !== 1'b0) rw_bad++;
    if (!iRST_N) begin
      in_pulse   = 0;
      first      = 1;
      last_clear = 0;
      hi_cnt     = 0;
      low_cnt    = 0;
    end else if (LCD_EN === 1'b1 && !in_pulse) begin
      in_pulse      = 1;
      hi_cnt        = 1;
      cur.rs        = LCD_RS;
      cur.data      = LCD_DATA;
      cur.stable    = (LCD_RS === prev_rs) && (LCD_DATA === prev_data);
      cur.gap       = low_cnt;
      cur.gap_valid = !first;
      cur.exp_gap   = (last_clear ? CLEAR_WAIT : CMD_WAIT) + GAP_OVH;
      cur.ready     = oREADY;
    end else if (LCD_EN === 1'b1) begin
      hi_cnt++;
      if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) cur.stable = 0;
    end else if (in_pulse) begin
      in_pulse   = 0;
      cur.hi     = hi_cnt;
      obs_q.push_back(cur);
      first      = 0;
      last_clear = (cur.rs == 1'b0) && (cur.data == 8'h01);
      low_cnt    = 1;
    end else begin
      low_cnt++;
    end
    prev_rs   = LCD_RS;
    prev_data = LCD_DATA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic get_pulse(output pulse_t p, output bit ok);
    int n;
    n  = 0;
    ok = 0;
    while (obs_q.size() == 0 && n < TMO) begin
      @(negedge iCLK);
      n++;
    end
    if (obs_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL pulse_timeout actual=none required=EN pulse within %0d cycles", TMO);
    end else begin
      p  = obs_q.pop_front();
      ok = 1;
    end
  endtask

  task automatic expect_byte(input logic rs, input logic [7:0] data);
    exp_q.push_back({rs, data});
  endtask

  task automatic expect_init();
    expect_byte(1'b0, 8'h38);
    expect_byte(1'b0, 8'h0C);
    expect_byte(1'b0, 8'h01);
    expect_byte(1'b0, 8'h06);
    expect_byte(1'b0, 8'h80);
  endtask

  task automatic expect_chars(input logic [63:0] ascii);
    logic [63:0] a;
    a = ascii;
`ifdef LCD_PREFIX_EN
    expect_byte(1'b1, 8'h30);
    expect_byte(1'b1, 8'h78);
`endif
    for (int i = 0; i < 8; i++) expect_byte(1'b1, a[63-8*i -: 8]);
  endtask

  task automatic drain(input string tag);
    pulse_t     p;
    bit         ok;
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      get_pulse(p, ok);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      chk({tag, "_byte"}, {23'h0, p.rs, p.data}, {23'h0, e});
      chk({tag, "_en_high"}, p.hi, EN_HIGH);
      chk({tag, "_stable"}, {31'h0, p.stable}, 32'd1);
      chk({tag, "_ready"}, {31'h0, p.ready}, {31'h0, !(e[8] == 1'b0 && e[7:0] != 8'h80)});
      if (p.gap_valid) chk({tag, "_gap"}, p.gap, p.exp_gap);
    end
  endtask

  task automatic sync_frame();
    pulse_t p;
    bit     ok;
    for (int n = 0; n < 40; n++) begin
      get_pulse(p, ok);
      if (!ok) return;
      if (p.rs == 1'b0 && p.data == 8'h80) return;
    end
    checks++;
    failures++;
    $display("FAIL frame_sync actual=no 80 required=80 within 40 pulses");
  endtask

  vec_t tbl[4];

  initial begin
    int n;
    tbl[0] = '{32'h89EF4567, 64'h3839454634353637};
    tbl[1] = '{32'hDEADBEEF, 64'h4445414442454546};
    tbl[2] = '{32'h00000000, 64'h3030303030303030};
    tbl[3] = '{32'h13579BDF, 64'h3133353739424446};

    iRST_N = 1'b0;
    Msg    = 32'h0123ABCD;
    repeat (3) @(negedge iCLK);
    chk("reset_en",    {31'h0, LCD_EN}, 32'd0);
    chk("reset_data",  {24'h0, LCD_DATA}, 32'd0);
    chk("reset_rs",    {31'h0, LCD_RS}, 32'd0);
    chk("reset_ready", {31'h0, oREADY}, 32'd0);

    // Init sequence then two identical frames of 0123ABCD
    iRST_N = 1'b1;
    expect_init();
    expect_chars(64'h3031323341424344);
    expect_byte(1'b0, 8'h80);
    expect_chars(64'h3031323341424344);
    drain("init");

    for (int t = 0; t < 4; t++) begin
      Msg = tbl[t].msg;
      obs_q.delete();
      sync_frame();
      sync_frame();
      expect_chars(tbl[t].ascii);
      expect_byte(1'b0, 8'h80);
      drain($sformatf("vec%0d", t));
    end

    // Msg change mid-frame must not tear the frame in progress
    Msg = 32'hFFFFFFFF;
    obs_q.delete();
    sync_frame();
    sync_frame();
`ifdef LCD_PREFIX_EN
    expect_byte(1'b1, 8'h30);
    expect_byte(1'b1, 8'h78);
`endif
    expect_byte(1'b1, 8'h46);
    expect_byte(1'b1, 8'h46);
    drain("tear_a");
    Msg = 32'h0;
    for (int i = 0; i < 6; i++) expect_byte(1'b1, 8'h46);
    expect_byte(1'b0, 8'h80);
    expect_chars(64'h3030303030303030);
    drain("tear_b");

    // Asynchronous reset in the middle of an EN pulse
    n = 0;
    while (LCD_EN !== 1'b1 && n < TMO) begin
      @(negedge iCLK);
      n++;
    end
    chk("rst_en_seen", {31'h0, LCD_EN}, 32'd1);
    iRST_N = 1'b0;
    #1;
    chk("rst_async_en",    {31'h0, LCD_EN}, 32'd0);
    chk("rst_async_data",  {24'h0, LCD_DATA}, 32'd0);
    chk("rst_async_ready", {31'h0, oREADY}, 32'd0);
    chk("rst_async_rs",    {31'h0, LCD_RS}, 32'd0);
    repeat (3) @(negedge iCLK);
    obs_q.delete();
    exp_q.delete();
    iRST_N = 1'b1;
    expect_init();
    drain("rerun");

    chk("rw_low", rw_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
